escalar_alu_sched: RTL

//  Shares one combinational escalar_ALU between N_REQ requesters, e.g. the scalar pipe and the interpolation address generator.

---
 rtl/escalar_pkg.sv | 36 +++
 rtl/escalar_alu_sched_rr_arbiter.sv | 34 +++
 rtl/escalar_alu_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/escalar_pkg.sv
// Shared types for the escalar ALU scheduler: opcodes, flag layout and FSM states.
package escalar_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    SLL = 3'd3,
    AND = 3'd4,
    OR  = 3'd5
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic neg;
    logic eq;
    logic bgt;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int OP_W    = 3;
  localparam int FLAGS_W = 6;

  // Opcodes 6 and 7 have no ALU function behind them.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/escalar_alu_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first pending requester strictly after i_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int            w_cand;
  logic [IW-1:0] w_cand_idx;

  always_comb begin
    o_gnt      = '0;
    o_idx      = '0;
    o_any      = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand     = (int'(i_ptr) + k) % N_REQ;
      w_cand_idx = IW'(w_cand);
      if (i_en && !o_any && i_req[w_cand_idx]) begin
        o_any             = 1'b1;
        o_idx             = w_cand_idx;
        o_gnt[w_cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/escalar_alu_sched.sv
// Shares one external combinational ALU between N_REQ requesters; one op in flight,
// MUL held on the ALU inputs for MUL_LAT cycles, result returned on a tagged response.
module escalar_alu_sched
  import escalar_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = 32,
  parameter int MUL_LAT = 2,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic [N_REQ*3-1:0] i_req_op,
  input  logic [N_REQ*W-1:0] i_req_a,
  input  logic [N_REQ*W-1:0] i_req_b,
  input  logic [N_REQ-1:0]   i_req_cin,
  output logic [2:0]         o_alu_op,
  output logic [W-1:0]       o_alu_a,
  output logic [W-1:0]       o_alu_b,
  output logic               o_alu_cin,
  input  logic [W-1:0]       i_alu_result,
  input  logic [5:0]         i_alu_flags,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [IW-1:0]      o_rsp_id,
  output logic [W-1:0]       o_rsp_result,
  output logic [5:0]         o_rsp_flags,
  output logic               o_rsp_err,
  output logic               o_busy
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  sched_state_t r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_alu_op;
  logic [W-1:0]  r_alu_a;
  logic [W-1:0]  r_alu_b;
  logic          r_alu_cin;
  logic          r_rsp_valid;
  logic [IW-1:0] r_rsp_id;
  logic [W-1:0]  r_rsp_result;
  alu_flags_t    r_rsp_flags;
  logic          r_rsp_err;
  logic          r_busy;

  logic [2:0]    w_op [N_REQ];
  logic [W-1:0]  w_a  [N_REQ];
  logic [W-1:0]  w_b  [N_REQ];
  logic          w_idle;
  logic          w_gnt_any;
  logic [IW-1:0] w_gnt_idx;
  logic [2:0]    w_sel_op;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_op[gi] = i_req_op[gi*3 +: 3];
    assign w_a[gi]  = i_req_a[gi*W +: W];
    assign w_b[gi]  = i_req_b[gi*W +: W];
  end

  assign w_idle   = (r_state == IDLE);
  assign w_sel_op = w_op[w_gnt_idx];

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .i_en  (w_idle),
    .o_gnt (o_req_ready),
    .o_idx (w_gnt_idx),
    .o_any (w_gnt_any)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= IW'(N_REQ - 1);
      r_cnt        <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_cin    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_any) begin
            r_rr_ptr  <= w_gnt_idx;
            r_rsp_id  <= w_gnt_idx;
            r_alu_op  <= w_sel_op;
            r_alu_a   <= w_a[w_gnt_idx];
            r_alu_b   <= w_b[w_gnt_idx];
            r_alu_cin <= i_req_cin[w_gnt_idx];
            r_busy    <= 1'b1;
            if (op_is_legal(w_sel_op)) begin
              r_cnt   <= (w_sel_op == MUL) ? CW'(MUL_LAT - 1) : '0;
              r_state <= EXEC;
            end else begin
              // Illegal opcode never reaches the ALU; answer immediately with an error.
              r_rsp_result <= '0;
              r_rsp_flags  <= '0;
              r_rsp_err    <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_state      <= RESP;
            end
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_rsp_result <= i_alu_result;
            r_rsp_flags  <= alu_flags_t'(i_alu_flags);
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_alu_op     = r_alu_op;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_cin    = r_alu_cin;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = r_busy;

endmodule
